// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   REG_ZERO    - index of the hardwired-zero register
//   word_t      - widest register word the merge helper handles (MAX_W bits)
//   merge_mask  - bit-masked write merge: 1 = take new data, 0 = keep old
//   sb_width    - scoreboard vector width for a given address width
//   sb_vec_t    - scoreboard vector at the largest supported address width
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int MAX_W    = 64;   // merge_mask covers register widths up to this
    localparam int MAX_M    = 8;

    typedef logic [MAX_W-1:0]         word_t;
    typedef logic [(1<<MAX_M)-1:0]    sb_vec_t;

    function automatic word_t merge_mask(input word_t old, input word_t data, input word_t mask);
        return (old & ~mask) | (data & mask);
    endfunction

    function automatic int sb_width(input int m);
        return 1 << m;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy-bit scoreboard for the register file.
//   clk, rst        - clock, async active-high reset
//   wf, w1          - write enables / addresses; any enabled write clears busy
//   rsv, rsv_id     - reserve strobe / target; sets busy (wins over a clear)
//   busy            - current busy vector (straight from the flops)
//   busy_fwd        - busy vector seen by the read ports: post-update when
//                     BYPASS is set, otherwise identical to busy
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int M      = 5,
    parameter int NW     = 2,
    parameter bit BYPASS = 1'b0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [NW-1:0]     wf,
    input  logic [NW*M-1:0]   w1,
    input  logic              rsv,
    input  logic [M-1:0]      rsv_id,
    output logic [2**M-1:0]   busy,
    output logic [2**M-1:0]   busy_fwd
);

    logic [2**M-1:0] busy_nxt;

    // Clears first, then the reserve: a new producer issued in the same
    // cycle as the old result lands must keep the register busy.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NW; j++) begin
            if (wf[j]) busy_nxt[w1[j*M +: M]] = 1'b0;
        end
        if (rsv) busy_nxt[rsv_id] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    assign busy_fwd = BYPASS ? busy_nxt : busy;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with per-bit write
// masks, registered reads (1-cycle latency), hardwired-zero register 0 and a
// busy-bit scoreboard. Optional macro REGFILE_BYPASS_EN makes reads return
// the same-cycle post-write data and busy state.
//   clk, rst     - clock, async active-high reset
//   r  / v / vb  - read addresses in, registered data and busy bit out (NR ports)
//   wf/w1/mask/w - write enable, address, bit mask, data (NW ports, ascending
//                  port order; higher index wins on overlapping mask bits)
//   rsv, rsv_id  - reserve strobe / register to mark busy
//   busy         - current scoreboard vector
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int N  = 32,
    parameter int M  = 5,
    parameter int NR = 2,
    parameter int NW = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [NR*M-1:0]   r,
    output logic [NR*N-1:0]   v,
    output logic [NR-1:0]     vb,
    input  logic [NW-1:0]     wf,
    input  logic [NW*M-1:0]   w1,
    input  logic [NW*N-1:0]   mask,
    input  logic [NW*N-1:0]   w,
    input  logic              rsv,
    input  logic [M-1:0]      rsv_id,
    output logic [2**M-1:0]   busy
);

    localparam int D = sb_width(M);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [N-1:0]   regs     [D];
    logic [N-1:0]   regs_nxt [D];
    logic [D-1:0]   busy_fwd;
    word_t          merged;

    // Ports chain through regs_nxt so a later port merges onto an earlier
    // port's result when both target the same register.
    always_comb begin
        regs_nxt = regs;
        merged   = '0;
        for (int j = 0; j < NW; j++) begin
            if (wf[j]) begin
                merged = merge_mask(word_t'(regs_nxt[w1[j*M +: M]]),
                                    word_t'(w[j*N +: N]),
                                    word_t'(mask[j*N +: N]));
                regs_nxt[w1[j*M +: M]] = merged[N-1:0];
            end
        end
        regs_nxt[REG_ZERO] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) regs[i] <= '0;
        end else begin
            regs <= regs_nxt;
        end
    end

    regfile_scoreboard #(.M(M), .NW(NW), .BYPASS(BYPASS)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wf       (wf),
        .w1       (w1),
        .rsv      (rsv),
        .rsv_id   (rsv_id),
        .busy     (busy),
        .busy_fwd (busy_fwd)
    );

    // Register 0 never needs special-casing here: it is zero in both regs
    // and regs_nxt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v  <= '0;
            vb <= '0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                v[k*N +: N] <= BYPASS ? regs_nxt[r[k*M +: M]] : regs[r[k*M +: M]];
                vb[k]       <= busy_fwd[r[k*M +: M]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp at default parameters (N=32, M=5, NR=2, NW=2).
module tb_regfile_mp;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    r;
    logic [63:0]   v;
    logic [1:0]    vb;
    logic [1:0]    wf;
    logic [9:0]    w1;
    logic [63:0]   mask;
    logic [63:0]   w;
    logic          rsv;
    logic [4:0]    rsv_id;
    logic [31:0]   busy;

    int checks = 0;
    int errors = 0;

    regfile_mp dut (
        .clk    (clk),
        .rst    (rst),
        .r      (r),
        .v      (v),
        .vb     (vb),
        .wf     (wf),
        .w1     (w1),
        .mask   (mask),
        .w      (w),
        .rsv    (rsv),
        .rsv_id (rsv_id),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d, input logic [31:0] m);
        wf[port]          = 1'b1;
        w1[port*5 +: 5]   = a;
        w[port*32 +: 32]  = d;
        mask[port*32 +: 32] = m;
    endtask

    task automatic idle();
        wf   = '0;
        rsv  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; r = '0; wf = '0; w1 = '0; mask = '0; w = '0; rsv = 1'b0; rsv_id = '0;
        #2 rst = 1'b1;
        step(); step();
        chk("reset_v",    v[31:0], 32'h0);
        chk("reset_busy", busy,    32'h0);
        rst = 1'b0;

        // Populate some state, then reset over it.
        wr(0, 5'd1, 32'h12345678, 32'hFFFFFFFF);
        wr(1, 5'd2, 32'h9ABCDEF0, 32'hFFFFFFFF);
        rsv = 1'b1; rsv_id = 5'd4;
        r = {5'd4, 5'd1};
        step();
        chk("pre_reset_busy", busy, 32'h0000_0010);
        step();
        chk("pre_reset_v0", v[31:0], 32'h12345678);
        rst = 1'b1;
        #1;
        chk("async_reset_v0", v[31:0], 32'h0);
        chk("async_reset_vb", {30'd0, vb}, 32'h0);
        chk("async_reset_busy", busy, 32'h0);
        step(); step(); step();
        chk("held_reset_busy", busy, 32'h0);
        rst = 1'b0;
        idle();
        for (int a = 1; a < 32; a++) begin
            r = {5'(a), 5'(a)};
            step();
            chk($sformatf("post_reset_reg%0d", a), v[31:0], 32'h0);
        end
        chk("post_reset_vb", {30'd0, vb}, 32'h0);

        // Masked write: second write clears the low half only.
        wr(0, 5'd5, 32'hDEADBEEF, 32'hFFFFFFFF);
        step();
        wr(0, 5'd5, 32'h00000000, 32'h0000FFFF);
        step();
        idle();
        r = {5'd0, 5'd5};
        step();
        chk("masked_write_reg5", v[31:0], 32'hDEAD0000);

        // Two ports, same register, disjoint masks.
        wr(0, 5'd7, 32'h11111111, 32'hFF00FF00);
        wr(1, 5'd7, 32'h22222222, 32'h0000FFFF);
        step();
        idle();
        r = {5'd0, 5'd7};
        step();
        chk("dual_port_reg7", v[31:0], 32'h11002222);

        // Two ports, overlapping masks: port 1 wins on shared bits.
        wr(0, 5'd8, 32'hAAAAAAAA, 32'hFFFFFFFF);
        wr(1, 5'd8, 32'h55555555, 32'h0F0F0F0F);
        step();
        idle();
        r = {5'd8, 5'd0};
        step();
        chk("overlap_reg8", v[63:32], 32'hA5A5A5A5);

        // Register 0: write and reserve are both ignored.
        wr(0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        rsv = 1'b1; rsv_id = 5'd0;
        step();
        idle();
        chk("reg0_busy", busy, 32'h0);
        r = {5'd0, 5'd0};
        step();
        chk("reg0_v0", v[31:0], 32'h0);
        chk("reg0_vb", {30'd0, vb}, 32'h0);

        // Scoreboard: reserve, reserve+write, then mask-0 write.
        rsv = 1'b1; rsv_id = 5'd3;
        step();
        idle();
        chk("rsv_busy3", busy, 32'h0000_0008);
        rsv = 1'b1; rsv_id = 5'd3;
        wr(1, 5'd3, 32'h12345678, 32'hFFFFFFFF);
        step();
        idle();
        chk("rsv_plus_write_busy3", busy, 32'h0000_0008);
        r = {5'd3, 5'd0};
        step();
        chk("rsv_plus_write_data", v[63:32], 32'h12345678);
        chk("rsv_plus_write_vb1", {31'd0, vb[1]}, 32'h1);
        wr(0, 5'd3, 32'hFFFFFFFF, 32'h00000000);
        step();
        idle();
        chk("mask0_clears_busy", busy, 32'h0);
        r = {5'd0, 5'd3};
        step();
        chk("mask0_keeps_data", v[31:0], 32'h12345678);
        chk("mask0_vb0", {31'd0, vb[0]}, 32'h0);

        // Same-cycle read/write of reg 9 and reserve/read of reg 10.
        r = {5'd9, 5'd10};
        wr(0, 5'd9, 32'hCAFEF00D, 32'hFFFFFFFF);
        rsv = 1'b1; rsv_id = 5'd10;
        step();
        idle();
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_v1",  v[63:32], 32'hCAFEF00D);
        chk("same_cycle_vb0", {31'd0, vb[0]}, 32'h1);
`else
        chk("same_cycle_v1",  v[63:32], 32'h0);
        chk("same_cycle_vb0", {31'd0, vb[0]}, 32'h0);
`endif
        step();
        chk("after_write_v1",  v[63:32], 32'hCAFEF00D);
        chk("after_rsv_vb0",   {31'd0, vb[0]}, 32'h1);
        chk("final_busy",      busy, 32'h0000_0400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
